// File: rtl/vtu_cache_arbiter_pkg.sv
// Shared VTU types: block address/payload, requester id, and arbiter limits.
package vtu_cache_arbiter_pkg;

  localparam int unsigned VTU_ARB_MAX_REQ = 8;
  localparam int unsigned BLOCK_COORD_W   = 8;
  localparam int unsigned BLOCK_TYPE_W    = 8;

  typedef struct packed {
    logic [BLOCK_COORD_W-1:0] x;
    logic [BLOCK_COORD_W-1:0] y;
    logic [BLOCK_COORD_W-1:0] z;
  } BlockPos;

  typedef logic [BLOCK_TYPE_W-1:0] BlockType;

  typedef logic [$clog2(VTU_ARB_MAX_REQ)-1:0] ReqId;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO tracking which requester owns each outstanding cache read.
// Push when full and pop when empty are ignored, so count never wraps.
module arb_tag_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vtu_cache_arbiter.sv
// Round-robin arbiter sharing one cache read port among VTU requesters.
// Define VTU_ARB_PERF_CNT_EN to add saturating grant/stall counters.
module vtu_cache_arbiter
  import vtu_cache_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  BlockPos [NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic                cache_ready,
  output BlockPos             ram_addr,
  output logic                ram_read_enable,
  input  BlockType            ram_out,
  input  logic                ram_valid,
  output logic [NUM_REQ-1:0]  resp_valid,
  output BlockType            resp_data,
  output logic                busy_out,
`ifdef VTU_ARB_PERF_CNT_EN
  output logic [31:0]         grant_count_out,
  output logic [31:0]         stall_count_out,
`endif
  output logic                protocol_err_out
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ReqId               rr_ptr;
  ReqId               rr_next;
  ReqId               grant_idx;
  ReqId               fifo_tag;
  BlockPos            grant_addr;
  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] resp_valid_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_next;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant_en;
  logic               any_req;
  logic               transfer;
  logic               pop_ok;

  // Grant: lowest requester at/after rr_ptr, else lowest overall (wrap).
  always_comb begin
    masked_req = '0;
    grant_idx  = '0;
    req_ready  = '0;
    grant_addr = '0;
    any_req    = |req_valid;
    grant_en   = rst_in && cache_ready && !fifo_full;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked_req[i] = req_valid[i] && (ReqId'(i) >= rr_ptr);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) grant_idx = ReqId'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked_req[i]) grant_idx = ReqId'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && any_req && (grant_idx == ReqId'(i));
      if (grant_idx == ReqId'(i)) grant_addr = req_addr[i];
    end
  end

  assign transfer = |(req_valid & req_ready);
  assign pop_ok   = ram_valid && !fifo_empty;

  always_comb begin
    rr_next      = rr_ptr;
    resp_valid_d = '0;
    count_next   = fifo_count + CNT_W'(transfer) - CNT_W'(pop_ok);
    if (transfer) begin
      rr_next = (grant_idx == ReqId'(NUM_REQ - 1)) ? '0 : grant_idx + ReqId'(1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = pop_ok && (fifo_tag == ReqId'(i));
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(ReqId))
  ) u_tag_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (transfer),
    .push_data (grant_idx),
    .pop       (ram_valid),
    .pop_data  (fifo_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rr_ptr           <= '0;
      ram_read_enable  <= 1'b0;
      ram_addr         <= '0;
      resp_valid       <= '0;
      resp_data        <= '0;
      busy_out         <= 1'b0;
      protocol_err_out <= 1'b0;
    end else begin
      rr_ptr          <= rr_next;
      ram_read_enable <= transfer;
      if (transfer) ram_addr <= grant_addr;
      resp_valid      <= resp_valid_d;
      if (pop_ok) resp_data <= ram_out;
      busy_out        <= (count_next != '0);
      // Response with nothing outstanding is dropped and flagged until reset.
      if (ram_valid && fifo_empty) protocol_err_out <= 1'b1;
    end
  end

`ifdef VTU_ARB_PERF_CNT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      grant_count_out <= '0;
      stall_count_out <= '0;
    end else begin
      if (transfer && (grant_count_out != '1)) grant_count_out <= grant_count_out + 32'd1;
      if (any_req && !transfer && (stall_count_out != '1)) stall_count_out <= stall_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vtu_cache_arbiter.sv
// Directed scoreboard bench for vtu_cache_arbiter (NUM_REQ=4, MAX_OUTSTANDING=4).
module tb_vtu_cache_arbiter;
  import vtu_cache_arbiter_pkg::*;

  localparam int unsigned NREQ = 4;

  typedef struct packed {
    logic [NREQ-1:0] who;
    BlockType        data;
  } exp_t;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [NREQ-1:0]     req_valid;
  BlockPos [NREQ-1:0]  req_addr;
  logic [NREQ-1:0]     req_ready;
  logic                cache_ready;
  BlockPos             ram_addr;
  logic                ram_read_enable;
  BlockType            ram_out;
  logic                ram_valid;
  logic [NREQ-1:0]     resp_valid;
  BlockType            resp_data;
  logic                busy_out;
  logic                protocol_err_out;
`ifdef VTU_ARB_PERF_CNT_EN
  logic [31:0]         grant_count_out;
  logic [31:0]         stall_count_out;
`endif

  int       checks = 0;
  int       errors = 0;
  exp_t     exp_q[$];
  BlockPos  read_q[$];
  logic     auto_resp = 1'b0;
  BlockType data_next = '0;

  always #5 clk_in = ~clk_in;

  vtu_cache_arbiter #(.NUM_REQ(NREQ), .MAX_OUTSTANDING(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .cache_ready      (cache_ready),
    .ram_addr         (ram_addr),
    .ram_read_enable  (ram_read_enable),
    .ram_out          (ram_out),
    .ram_valid        (ram_valid),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .busy_out         (busy_out),
`ifdef VTU_ARB_PERF_CNT_EN
    .grant_count_out  (grant_count_out),
    .stall_count_out  (stall_count_out),
`endif
    .protocol_err_out (protocol_err_out)
  );

  function automatic BlockPos addr_of(input int i);
    return BlockPos'{x: 8'(160 + i), y: 8'h5C, z: 8'(3 * i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log issued reads; pop the scoreboard on every response strobe.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (ram_read_enable) read_q.push_back(ram_addr);
    if (resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_resp: observed %0h expected 0", resp_valid);
      end else begin
        e = exp_q.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(e.who));
        chk("resp_data", 32'(resp_data), 32'(e.data));
      end
    end
  end

  // Advance one cycle; in auto mode answer the oldest logged read.
  task automatic tick();
    BlockPos a;
    @(posedge clk_in);
    #1;
    if (auto_resp) begin
      if (read_q.size() > 0) begin
        a = read_q.pop_front();
        ram_valid = 1'b1;
        ram_out   = data_next;
        exp_q.push_back(exp_t'{who: NREQ'(1) << (a.x - 8'hA0), data: data_next});
        data_next = data_next + 8'd1;
      end else begin
        ram_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    auto_resp = 1'b0;
    ram_valid = 1'b0;
    req_valid = '0;
    rst_in    = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    read_q.delete();
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && (read_q.size() > 0 || exp_q.size() > 0); n++) tick();
    auto_resp = 1'b0;
    ram_valid = 1'b0;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int ng;
    rst_in      = 1'b0;
    cache_ready = 1'b1;
    ram_valid   = 1'b0;
    ram_out     = '0;
    for (int i = 0; i < NREQ; i++) req_addr[i] = addr_of(i);
    req_valid = '1;

    // Reset state, with requests pending
    tick();
    tick();
    @(negedge clk_in);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_re", 32'(ram_read_enable), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_perr", 32'(protocol_err_out), 32'd0);
`ifdef VTU_ARB_PERF_CNT_EN
    chk("rst_grant_cnt", grant_count_out, 32'd0);
    chk("rst_stall_cnt", stall_count_out, 32'd0);
`endif
    tick();
    rst_in    = 1'b1;
    req_valid = 4'b0010;

    // Single request
    @(negedge clk_in);
    chk("single_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    @(negedge clk_in);
    chk("single_re", 32'(ram_read_enable), 32'd1);
    chk("single_addr", 32'(ram_addr), 32'(addr_of(1)));
    chk("single_busy", 32'(busy_out), 32'd1);
    tick();
    @(negedge clk_in);
    chk("single_re_pulse", 32'(ram_read_enable), 32'd0);
    chk("single_addr_hold", 32'(ram_addr), 32'(addr_of(1)));
    tick();
    read_q.delete();
    ram_valid = 1'b1;
    ram_out   = 8'd7;
    exp_q.push_back(exp_t'{who: 4'b0010, data: 8'd7});
    tick();
    ram_valid = 1'b0;
    @(negedge clk_in);
    chk("single_busy_clr", 32'(busy_out), 32'd0);
    tick();
    tick();
    chk("single_sb", 32'(exp_q.size()), 32'd0);

    // Fairness: all requesting, cache answering
    do_reset();
    req_valid = '1;
    data_next = 8'h20;
    auto_resp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      chk("fair_grant", 32'(req_ready), 32'(1) << (k % 4));
      tick();
    end
    req_valid = '0;
    drain();
    @(negedge clk_in);
    chk("fair_busy", 32'(busy_out), 32'd0);
`ifdef VTU_ARB_PERF_CNT_EN
    chk("fair_grant_cnt", grant_count_out, 32'd8);
`endif

    // Backpressure at MAX_OUTSTANDING
    do_reset();
    req_valid = '1;
    ng = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      if ((req_valid & req_ready) != '0) begin
        chk("bp_order", 32'(req_ready), 32'(1) << ng);
        ng++;
      end
      tick();
    end
    chk("bp_grants", 32'(ng), 32'd4);
    @(negedge clk_in);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_busy", 32'(busy_out), 32'd1);
    chk("bp_reads", 32'(read_q.size()), 32'd4);
    data_next = 8'd1;
    auto_resp = 1'b1;
    tick();
    @(negedge clk_in);
    chk("bp_pop_no_grant", 32'(req_ready), 32'd0);
    req_valid = '0;
    drain();
    @(negedge clk_in);
    chk("bp_busy_clr", 32'(busy_out), 32'd0);

    // Gating on cache_ready
    do_reset();
    cache_ready = 1'b0;
    req_valid   = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk("gate_ready", 32'(req_ready), 32'd0);
      chk("gate_re", 32'(ram_read_enable), 32'd0);
      tick();
    end
`ifdef VTU_ARB_PERF_CNT_EN
    chk("gate_stall_cnt", stall_count_out, 32'd10);
`endif
    cache_ready = 1'b1;
    #1;
    chk("gate_release", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    data_next = 8'h33;
    auto_resp = 1'b1;
    drain();

    // Protocol error, then reset with reads outstanding
    do_reset();
    ram_valid = 1'b1;
    ram_out   = 8'hEE;
    tick();
    ram_valid = 1'b0;
    @(negedge clk_in);
    chk("perr_set", 32'(protocol_err_out), 32'd1);
    chk("perr_no_resp", 32'(resp_valid), 32'd0);
    tick();
    @(negedge clk_in);
    chk("perr_sticky", 32'(protocol_err_out), 32'd1);
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    @(negedge clk_in);
    chk("mid_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b0;
    tick();
    @(negedge clk_in);
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    chk("mid_rst_perr", 32'(protocol_err_out), 32'd0);
    tick();
    rst_in = 1'b1;
    read_q.delete();
    @(negedge clk_in);
    chk("post_rst_busy", 32'(busy_out), 32'd0);
    tick();
    ram_valid = 1'b1;
    ram_out   = 8'h44;
    tick();
    ram_valid = 1'b0;
    @(negedge clk_in);
    chk("late_perr", 32'(protocol_err_out), 32'd1);
    chk("late_no_resp", 32'(resp_valid), 32'd0);
    tick();
    tick();
    chk("final_sb", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vtu_cache_arbiter.md
VTU_CACHE_ARBITER -- requirements
Module: vtu_cache_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of voxel traversal unit requesters (2..8).
REQ-002 Parameter MAX_OUTSTANDING, default 4: maximum issued-but-unanswered cache reads (power of 2).
REQ-003 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester read request.
REQ-006 req_addr  input  NUM_REQ x BlockPos  per-requester block address.
REQ-007 req_ready  output  NUM_REQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 cache_ready  input  1  cache initialized and readable.
REQ-009 ram_addr  output  BlockPos  address to the cache read port.
REQ-010 ram_read_enable  output  1  single-cycle cache read strobe.
REQ-011 ram_out  input  BlockType  cache read data.
REQ-012 ram_valid  input  1  ram_out valid; responses return in issue order.
REQ-013 resp_valid  output  NUM_REQ  one-hot response strobe.
REQ-014 resp_data  output  BlockType  response data, broadcast to all requesters.
REQ-015 busy_out  output  1  high while any read is outstanding.
REQ-016 protocol_err_out  output  1  sticky flag: ram_valid received with no read outstanding.

Function
REQ-017 req_ready is combinational; at most one bit is high per cycle.
REQ-018 No grant is issued while cache_ready is low or while the registered outstanding count equals MAX_OUTSTANDING; a pop in the same cycle does not unblock the grant.
REQ-019 Round-robin: the grant goes to the first asserted req_valid at or after pointer rr_ptr, searching with wrap from NUM_REQ-1 to 0.
REQ-020 On a transfer, rr_ptr becomes (granted index + 1) mod NUM_REQ. rr_ptr holds when there is no transfer.
REQ-021 The cycle after a transfer, ram_read_enable is 1 for exactly one cycle and ram_addr carries the granted req_addr (registered). ram_addr holds its last value otherwise.
REQ-022 On each transfer, the granted index is pushed into an in-order tag FIFO. On each ram_valid, the tag FIFO is popped.
REQ-023 On ram_valid with a non-empty FIFO: in the next cycle, resp_valid has the popped tag's bit high for exactly one cycle and resp_data = ram_out registered.
REQ-024 On ram_valid with an empty FIFO: the response is dropped, resp_valid stays 0, and protocol_err_out is set until reset.
REQ-025 Simultaneous push and pop in the same cycle leaves the outstanding count unchanged. The count never exceeds MAX_OUTSTANDING and never underflows.
REQ-026 busy_out = (outstanding count != 0), registered.
REQ-027 A requester holds req_valid and req_addr stable until its transfer. The arbiter does not check this.

Reset
REQ-028 While rst_in is 0: rr_ptr=0, FIFO empty, count=0, ram_read_enable=0, ram_addr=0, resp_valid=0, resp_data=0, busy_out=0, protocol_err_out=0, req_ready=0.
REQ-029 Reset mid-operation discards all outstanding tags. Any ram_valid arriving after reset is handled per REQ-024.

Configuration
REQ-030 Macro VTU_ARB_PERF_CNT_EN defined: adds outputs grant_count_out[31:0] and stall_count_out[31:0].
- grant_count_out increments per transfer.
- stall_count_out increments per cycle in which any req_valid is high with no transfer.
- Both reset to 0 and saturate at 32'hFFFF_FFFF.
REQ-031 Macro undefined: these ports and counters are absent. All other behaviour is identical.

Structure
REQ-032 BlockPos and BlockType come from the existing shared types package.
REQ-033 The shared package gains a ReqId typedef ($clog2 of max NUM_REQ 8 = 3 bits) and the VTU_ARB_MAX_REQ=8 constant.
REQ-034 The tag FIFO is a sub-module, arb_tag_fifo (parameters DEPTH and WIDTH; synchronous active-low reset; push, pop, full, empty, count).

Verification
REQ-035 Single request: req_valid=4'b0010, addr A, cache_ready=1.
- Expected: req_ready=4'b0010 in the same cycle; ram_read_enable pulse with ram_addr=A one cycle later.
- ram_valid with data 7 gives resp_valid=4'b0010 and resp_data=7 one cycle later.
REQ-036 Fairness: req_valid=4'b1111 held for 8 transfers (cache responding).
- Expected grant order: 0,1,2,3,0,1,2,3.
- With perf enabled: grant_count_out=8.
REQ-037 Backpressure: withhold ram_valid with MAX_OUTSTANDING=4.
- Expected: exactly 4 transfers, then req_ready=0 and busy_out=1.
- Returning data 1..4 yields responses to the requesters in grant order.
REQ-038 Gating: cache_ready=0 with req_valid=4'b0001 for 10 cycles.
- Expected: no grant and no ram_read_enable.
- With perf enabled: stall_count_out=10.
- Raising cache_ready produces a grant in the same cycle.
REQ-039 Protocol error and reset: ram_valid pulse with FIFO empty → protocol_err_out=1 and no resp_valid.
- Then rst_in=0 with 2 reads outstanding → count=0 and busy_out=0.
- A late ram_valid after reset sets protocol_err_out=1 again.
